// File: rtl/usb_fs_link_ctrl.sv
// rtl/usb_fs_link_ctrl.sv - USB full-speed link-state controller (bus reset / suspend / resume)
//
// Purpose: watches the synchronised D+/D- receive pair and valid-SOF strobes,
// tracks the USB link state and holds the protocol engine in reset while the
// device is disconnected or the host drives a bus reset.
//
// Ports:
//   clk_48mhz_i         48 MHz clock
//   rst_i               asynchronous active-high reset
//   enable_i            pull-up enabled; low forces DISCONNECTED
//   usb_p_rx_i          D+ receive (synchronised)
//   usb_n_rx_i          D- receive (synchronised)
//   sof_valid_i         valid-SOF strobe from the protocol engine
//   link_reset_o        high in DISCONNECTED and BUS_RESET
//   link_state_o        current link state code
//   link_reset_evt_o    one-cycle pulse on entry to BUS_RESET
//   link_suspend_evt_o  one-cycle pulse on entry to SUSPEND
//   link_resume_evt_o   one-cycle pulse on resume out of SUSPEND
module usb_fs_link_ctrl #(
  parameter int BusResetCycles = 120,
  parameter int SuspendCycles  = 144000,
  parameter int ResumeCycles   = 2,
  parameter int CntW           = 18
) (
  input  logic       clk_48mhz_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       usb_p_rx_i,
  input  logic       usb_n_rx_i,
  input  logic       sof_valid_i,
  output logic       link_reset_o,
  output logic [2:0] link_state_o,
  output logic       link_reset_evt_o,
  output logic       link_suspend_evt_o,
  output logic       link_resume_evt_o
);

  typedef enum logic [2:0] {
    ST_DISCONNECTED = 3'd0,
    ST_POWERED      = 3'd1,
    ST_BUS_RESET    = 3'd2,
    ST_ACTIVE_NOSOF = 3'd3,
    ST_ACTIVE       = 3'd4,
    ST_SUSPEND      = 3'd5
  } link_state_t;

  localparam logic [CntW-1:0] LP_ONE     = CntW'(1);
  localparam logic [CntW-1:0] LP_BR_CAP  = CntW'(BusResetCycles);
  localparam logic [CntW-1:0] LP_BR_THR  = CntW'(BusResetCycles - 1);
  localparam logic [CntW-1:0] LP_SUS_CAP = CntW'(SuspendCycles);
  localparam logic [CntW-1:0] LP_SUS_THR = CntW'(SuspendCycles - 1);
  localparam logic [CntW-1:0] LP_RES_CAP = CntW'(ResumeCycles);
  localparam logic [CntW-1:0] LP_RES_THR = CntW'(ResumeCycles - 1);

  link_state_t     r_state;
  logic            r_pre_active;   // 1: suspended from ACTIVE, 0: from ACTIVE_NOSOF
  logic            r_link_reset;
  logic            r_reset_evt;
  logic            r_suspend_evt;
  logic            r_resume_evt;
  logic [CntW-1:0] r_se0_cnt;
  logic [CntW-1:0] r_idle_cnt;
  logic [CntW-1:0] r_k_cnt;

  logic w_se0;
  logic w_j;
  logic w_k;
  logic w_in_active;
  logic w_br_capable;
  logic w_bus_rst_hit;
  logic w_suspend_hit;
  logic w_resume_hit;

  // SE1 decodes as neither SE0, J nor K.
  assign w_se0 = ~usb_p_rx_i & ~usb_n_rx_i;
  assign w_j   =  usb_p_rx_i & ~usb_n_rx_i;
  assign w_k   = ~usb_p_rx_i &  usb_n_rx_i;

  assign w_in_active  = (r_state == ST_ACTIVE_NOSOF) || (r_state == ST_ACTIVE);
  assign w_br_capable = (r_state == ST_POWERED) || w_in_active || (r_state == ST_SUSPEND);

  // Threshold hits fire on the edge sampling the N-th consecutive symbol.
  assign w_bus_rst_hit = w_br_capable && w_se0 && (r_se0_cnt == LP_BR_THR);
  assign w_suspend_hit = w_in_active && w_j && !sof_valid_i && (r_idle_cnt == LP_SUS_THR);
  assign w_resume_hit  = (r_state == ST_SUSPEND) && w_k && (r_k_cnt == LP_RES_THR);

  always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_DISCONNECTED;
      r_pre_active  <= 1'b0;
      r_link_reset  <= 1'b1;
      r_reset_evt   <= 1'b0;
      r_suspend_evt <= 1'b0;
      r_resume_evt  <= 1'b0;
      r_se0_cnt     <= '0;
      r_idle_cnt    <= '0;
      r_k_cnt       <= '0;
    end else begin
      r_reset_evt   <= 1'b0;
      r_suspend_evt <= 1'b0;
      r_resume_evt  <= 1'b0;

      if (!enable_i) begin
        r_state      <= ST_DISCONNECTED;
        r_link_reset <= 1'b1;
        r_se0_cnt    <= '0;
        r_idle_cnt   <= '0;
        r_k_cnt      <= '0;
      end else begin
        // Counters are saturating run-length counters on the current sample.
        if (!w_se0) begin
          r_se0_cnt <= '0;
        end else if (r_se0_cnt != LP_BR_CAP) begin
          r_se0_cnt <= r_se0_cnt + LP_ONE;
        end

        // An SOF proves the host is alive, so it restarts the idle run.
        if (!(w_in_active && w_j && !sof_valid_i)) begin
          r_idle_cnt <= '0;
        end else if (r_idle_cnt != LP_SUS_CAP) begin
          r_idle_cnt <= r_idle_cnt + LP_ONE;
        end

        if (!((r_state == ST_SUSPEND) && w_k)) begin
          r_k_cnt <= '0;
        end else if (r_k_cnt != LP_RES_CAP) begin
          r_k_cnt <= r_k_cnt + LP_ONE;
        end

        // Bus reset outranks SOF, suspend and resume handling.
        if (w_bus_rst_hit) begin
          r_state      <= ST_BUS_RESET;
          r_link_reset <= 1'b1;
          r_reset_evt  <= 1'b1;
        end else begin
          case (r_state)
            ST_DISCONNECTED: begin
              r_state      <= ST_POWERED;
              r_link_reset <= 1'b0;
            end
            ST_POWERED: begin
              r_link_reset <= 1'b0;
            end
            ST_BUS_RESET: begin
              if (!w_se0) begin
                r_state      <= ST_ACTIVE_NOSOF;
                r_link_reset <= 1'b0;
              end
            end
            ST_ACTIVE_NOSOF: begin
              if (sof_valid_i) begin
                r_state <= ST_ACTIVE;
              end else if (w_suspend_hit) begin
                r_state       <= ST_SUSPEND;
                r_pre_active  <= 1'b0;
                r_suspend_evt <= 1'b1;
              end
            end
            ST_ACTIVE: begin
              if (w_suspend_hit) begin
                r_state       <= ST_SUSPEND;
                r_pre_active  <= 1'b1;
                r_suspend_evt <= 1'b1;
              end
            end
            ST_SUSPEND: begin
              if (w_resume_hit) begin
                r_state      <= r_pre_active ? ST_ACTIVE : ST_ACTIVE_NOSOF;
                r_resume_evt <= 1'b1;
              end
            end
            default: begin
              r_state      <= ST_DISCONNECTED;
              r_link_reset <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign link_state_o       = r_state;
  assign link_reset_o       = r_link_reset;
  assign link_reset_evt_o   = r_reset_evt;
  assign link_suspend_evt_o = r_suspend_evt;
  assign link_resume_evt_o  = r_resume_evt;

endmodule

// File: tb/tb_usb_fs_link_ctrl.sv
// tb/tb_usb_fs_link_ctrl.sv - self-checking bench for usb_fs_link_ctrl
module tb_usb_fs_link_ctrl;

  localparam int BR  = 8;
  localparam int SUS = 64;
  localparam int RES = 2;

  localparam int SYM_SE0 = 0;
  localparam int SYM_J   = 1;
  localparam int SYM_K   = 2;
  localparam int SYM_SE1 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       p   = 1'b1;
  logic       n   = 1'b0;
  logic       sof = 1'b0;
  logic       link_reset;
  logic [2:0] link_state;
  logic       reset_evt;
  logic       suspend_evt;
  logic       resume_evt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: link state as an integer code plus run lengths.
  int m_state;
  int m_se0_run;
  int m_idle_run;
  int m_k_run;
  bit m_from_active;
  bit m_reset_evt;
  bit m_suspend_evt;
  bit m_resume_evt;

  usb_fs_link_ctrl #(
    .BusResetCycles(BR),
    .SuspendCycles (SUS),
    .ResumeCycles  (RES),
    .CntW          (18)
  ) u_dut (
    .clk_48mhz_i       (clk),
    .rst_i             (rst),
    .enable_i          (en),
    .usb_p_rx_i        (p),
    .usb_n_rx_i        (n),
    .sof_valid_i       (sof),
    .link_reset_o      (link_reset),
    .link_state_o      (link_state),
    .link_reset_evt_o  (reset_evt),
    .link_suspend_evt_o(suspend_evt),
    .link_resume_evt_o (resume_evt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state       = 0;
    m_se0_run     = 0;
    m_idle_run    = 0;
    m_k_run       = 0;
    m_from_active = 1'b0;
    m_reset_evt   = 1'b0;
    m_suspend_evt = 1'b0;
    m_resume_evt  = 1'b0;
  endtask

  task automatic model_step(input bit lp, input bit ln, input bit lsof, input bit len);
    bit is_se0, is_j, is_k, active, hit_br;
    int nxt;
    is_se0 = !lp && !ln;
    is_j   = lp && !ln;
    is_k   = !lp && ln;
    m_reset_evt   = 1'b0;
    m_suspend_evt = 1'b0;
    m_resume_evt  = 1'b0;
    if (!len) begin
      m_state    = 0;
      m_se0_run  = 0;
      m_idle_run = 0;
      m_k_run    = 0;
      return;
    end
    active = (m_state == 3) || (m_state == 4);
    hit_br = is_se0 && (m_se0_run == BR - 1) &&
             (m_state == 1 || m_state == 3 || m_state == 4 || m_state == 5);
    nxt = m_state;
    if (m_state == 0) nxt = 1;
    else if (hit_br) begin
      nxt = 2;
      m_reset_evt = 1'b1;
    end else if (m_state == 2 && !is_se0) nxt = 3;
    else if (m_state == 3 && lsof) nxt = 4;
    else if (active && is_j && !lsof && m_idle_run == SUS - 1) begin
      nxt = 5;
      m_from_active = (m_state == 4);
      m_suspend_evt = 1'b1;
    end else if (m_state == 5 && is_k && m_k_run == RES - 1) begin
      nxt = m_from_active ? 4 : 3;
      m_resume_evt = 1'b1;
    end
    m_se0_run  = is_se0 ? min_i(m_se0_run + 1, BR) : 0;
    m_idle_run = (active && is_j && !lsof) ? min_i(m_idle_run + 1, SUS) : 0;
    m_k_run    = (m_state == 5 && is_k) ? min_i(m_k_run + 1, RES) : 0;
    m_state    = nxt;
  endtask

  task automatic step(input bit lp, input bit ln, input bit lsof);
    p   = lp;
    n   = ln;
    sof = lsof;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step(lp, ln, lsof, en);
    check_eq("state", link_state, m_state);
    check_eq("link_reset", link_reset, (m_state == 0 || m_state == 2) ? 1 : 0);
    check_eq("reset_evt", reset_evt, m_reset_evt);
    check_eq("suspend_evt", suspend_evt, m_suspend_evt);
    check_eq("resume_evt", resume_evt, m_resume_evt);
  endtask

  task automatic run(input int sym, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      case (sym)
        SYM_SE0: step(1'b0, 1'b0, 1'b0);
        SYM_J:   step(1'b1, 1'b0, 1'b0);
        SYM_K:   step(1'b0, 1'b1, 1'b0);
        default: step(1'b1, 1'b1, 1'b0);
      endcase
    end
  endtask

  initial begin
    model_reset();

    // Power-up
    run(SYM_J, 2);
    check_eq("rst_state", link_state, 0);
    check_eq("rst_link_reset", link_reset, 1);
    rst = 1'b0;
    run(SYM_J, 1);
    check_eq("pwr_state", link_state, 1);

    // Bus reset qualification
    run(SYM_SE0, 7);
    run(SYM_J, 1);
    check_eq("short_se0_state", link_state, 1);
    run(SYM_SE0, 8);
    check_eq("br_state", link_state, 2);
    check_eq("br_evt", reset_evt, 1);
    check_eq("br_link_reset", link_reset, 1);
    run(SYM_SE0, 3);
    check_eq("br_hold_evt", reset_evt, 0);
    run(SYM_J, 1);
    check_eq("br_exit_state", link_state, 3);
    check_eq("br_exit_link_reset", link_reset, 0);

    // SOF and suspend from ACTIVE, then resume
    step(1'b1, 1'b0, 1'b1);
    check_eq("sof_state", link_state, 4);
    run(SYM_J, 63);
    check_eq("pre_susp_state", link_state, 4);
    run(SYM_J, 1);
    check_eq("susp_state", link_state, 5);
    check_eq("susp_evt", suspend_evt, 1);
    run(SYM_J, 5);
    run(SYM_K, 1);
    run(SYM_J, 1);
    check_eq("k_glitch_state", link_state, 5);
    run(SYM_K, 2);
    check_eq("resume_state", link_state, 4);
    check_eq("resume_evt_dir", resume_evt, 1);

    // SOF in the threshold cycle cancels suspend
    run(SYM_J, 63);
    step(1'b1, 1'b0, 1'b1);
    check_eq("sof_cancel_state", link_state, 4);

    // Suspend/resume from ACTIVE_NOSOF
    run(SYM_SE0, 8);
    run(SYM_J, 1);
    run(SYM_J, 64);
    check_eq("nosof_susp_state", link_state, 5);
    run(SYM_K, 2);
    check_eq("nosof_resume_state", link_state, 3);

    // Bus reset beats resume in SUSPEND
    run(SYM_J, 64);
    run(SYM_SE0, 8);
    check_eq("susp_br_state", link_state, 2);
    check_eq("susp_br_no_resume", resume_evt, 0);

    // Disconnect from ACTIVE
    run(SYM_J, 1);
    step(1'b1, 1'b0, 1'b1);
    en = 1'b0;
    run(SYM_J, 1);
    check_eq("disc_state", link_state, 0);
    check_eq("disc_link_reset", link_reset, 1);
    en = 1'b1;
    run(SYM_J, 1);

    // Asynchronous reset between clock edges while ACTIVE
    run(SYM_SE0, 8);
    run(SYM_J, 1);
    step(1'b1, 1'b0, 1'b1);
    check_eq("pre_async_state", link_state, 4);
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_state", link_state, 0);
    check_eq("async_link_reset", link_reset, 1);
    check_eq("async_evts", {reset_evt, suspend_evt, resume_evt}, 0);
    model_reset();
    run(SYM_J, 2);
    rst = 1'b0;

    // Randomised line activity
    for (int seg = 0; seg < 160; seg++) begin
      int r;
      int sym;
      int len;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        en = 1'b0;
        run(SYM_J, $urandom_range(1, 3));
        en = 1'b1;
      end else if (r < 7) begin
        rst = 1'b1;
        run(SYM_J, 1);
        rst = 1'b0;
      end else begin
        if (r < 45) begin
          sym = SYM_J;
          len = $urandom_range(1, 80);
        end else if (r < 70) begin
          sym = SYM_SE0;
          len = $urandom_range(1, 12);
        end else if (r < 92) begin
          sym = SYM_K;
          len = $urandom_range(1, 3);
        end else begin
          sym = SYM_SE1;
          len = $urandom_range(1, 3);
        end
        for (int c = 0; c < len; c++) begin
          bit s;
          s = ($urandom_range(0, 19) == 0);
          case (sym)
            SYM_SE0: step(1'b0, 1'b0, s);
            SYM_J:   step(1'b1, 1'b0, s);
            SYM_K:   step(1'b0, 1'b1, s);
            default: step(1'b1, 1'b1, s);
          endcase
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
